div_unit: RTL



---
 rtl/div_pkg.sv | 32 +++
 rtl/div_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_pkg.sv
// Shared encodings, state enum and constants for the iterative RV32M divider (div_unit).
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  localparam int          DIV_ITER   = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // DivOp bit 0 marks the unsigned variants, bit 1 selects the remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divide/remainder unit for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_REUSE_EN keeps the last completed result pair for same-operand reuse.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [1:0]      DivOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] DivResult
);

  div_state_e      state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [1:0]      op_q, op_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

`ifdef DIV_REUSE_EN
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic            last_vld_q, last_vld_d;
  logic [XLEN-1:0] last_a_q, last_a_d;
  logic [XLEN-1:0] last_b_q, last_b_d;
  logic            last_uns_q, last_uns_d;
  logic [XLEN-1:0] last_quot_q, last_quot_d;
  logic [XLEN-1:0] last_rem_q, last_rem_d;
  logic            reuse_hit;
`endif

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            sgn_ovf;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic            rem_ge;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign is_signed = op_is_signed(DivOp);
  assign a_neg     = is_signed & A[XLEN-1];
  assign b_neg     = is_signed & B[XLEN-1];
  assign a_abs     = neg_if(A, a_neg);
  assign b_abs     = neg_if(B, b_neg);
  assign div_zero  = (B == '0);
  assign sgn_ovf   = is_signed && (A == INT_MIN) && (B == '1);

  // The partial remainder stays below the divisor, so the 33-bit difference
  // never wraps and its top bit is a true borrow.
  assign rem_shift = {rem_q, dvd_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor_q};
  assign rem_ge    = ~rem_diff[XLEN];

  assign q_fix = neg_if(dvd_q, q_neg_q);
  assign r_fix = neg_if(rem_q, r_neg_q);

`ifdef DIV_REUSE_EN
  assign reuse_hit = last_vld_q && (A == last_a_q) && (B == last_b_q) && (DivOp[0] == last_uns_q);
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    divisor_d = divisor_q;
    op_d      = op_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    done_d    = 1'b0;
`ifdef DIV_REUSE_EN
    opa_d       = opa_q;
    opb_d       = opb_q;
    last_vld_d  = last_vld_q;
    last_a_d    = last_a_q;
    last_b_d    = last_b_q;
    last_uns_d  = last_uns_q;
    last_quot_d = last_quot_q;
    last_rem_d  = last_rem_q;
`endif

    case (state_q)
      IDLE: begin
        // Flush wins over Start; special cases load the final quotient/remainder directly.
        if (Start && !Flush) begin
          op_d      = DivOp;
          q_neg_d   = 1'b0;
          r_neg_d   = 1'b0;
          divisor_d = b_abs;
          count_d   = '0;
`ifdef DIV_REUSE_EN
          opa_d = A;
          opb_d = B;
`endif
          if (div_zero) begin
            dvd_d   = DIV_ZERO_Q;
            rem_d   = A;
            state_d = FIN;
          end else if (sgn_ovf) begin
            dvd_d   = INT_MIN;
            rem_d   = '0;
            state_d = FIN;
          end
`ifdef DIV_REUSE_EN
          else if (reuse_hit) begin
            dvd_d   = last_quot_q;
            rem_d   = last_rem_q;
            state_d = FIN;
          end
`endif
          else begin
            dvd_d   = a_abs;
            rem_d   = '0;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            count_d = 5'(DIV_ITER - 1);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (Flush) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          rem_d = rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
          dvd_d = {dvd_q[XLEN-2:0], rem_ge};
          if (count_q == '0) begin
            state_d = FIN;
          end else begin
            count_d = count_q - 5'd1;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        if (!Flush) begin
          result_d = op_is_rem(op_q) ? r_fix : q_fix;
          done_d   = 1'b1;
`ifdef DIV_REUSE_EN
          last_vld_d  = 1'b1;
          last_a_d    = opa_q;
          last_b_d    = opb_q;
          last_uns_d  = op_q[0];
          last_quot_d = q_fix;
          last_rem_d  = r_fix;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      op_q      <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
`ifdef DIV_REUSE_EN
      opa_q       <= '0;
      opb_q       <= '0;
      last_vld_q  <= 1'b0;
      last_a_q    <= '0;
      last_b_q    <= '0;
      last_uns_q  <= 1'b0;
      last_quot_q <= '0;
      last_rem_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      divisor_q <= divisor_d;
      op_q      <= op_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
`ifdef DIV_REUSE_EN
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      last_vld_q  <= last_vld_d;
      last_a_q    <= last_a_d;
      last_b_q    <= last_b_d;
      last_uns_q  <= last_uns_d;
      last_quot_q <= last_quot_d;
      last_rem_q  <= last_rem_d;
`endif
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivResult = result_q;

endmodule
